// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: EXE operand select codes and shadow-entry control bits.
package cpu_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares two source registers against one in-flight destination register.
// Pure combinational; a hit needs a writing, valid stage, a used source and (optionally) a non-zero register.
module hazard_cmp #(
  parameter int AW     = 5,
  parameter bit ZERO_R = 1'b1
) (
  input  logic          st_wr,
  input  logic [AW-1:0] st_waddr,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic          use_a,
  input  logic          use_b,
  output logic          hit_a,
  output logic          hit_b
);

  logic zero_a, zero_b;

  assign zero_a = ZERO_R && (src_a == '0);
  assign zero_b = ZERO_R && (src_b == '0);
  assign hit_a  = st_wr & use_a & (st_waddr == src_a) & ~zero_a;
  assign hit_b  = st_wr & use_b & (st_waddr == src_b) & ~zero_b;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard control: enables, bubbles/flushes, EXE forwarding, WB->ID bypass, perf counters.
// HAZARD_CTRL_FWD_EN selects forwarding + load-use interlock; without it every RAW hazard stalls in ID.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int AW     = 5,
  parameter int CNT_W  = 16,
  parameter int ZERO_R = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [AW-1:0]    id_waddr,
  input  logic             mem_redirect,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    stage_ctl_t    ctl;
    logic [AW-1:0] waddr;
  } shadow_t;

  shadow_t          id_ent, exe_q, mem_q, wb_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             freeze, redirect, hazard, load_use, stall_inc;
  logic             ie_a, ie_b, iw_a, iw_b;
  logic             unused_ctl;

  assign id_ent     = {id_valid, id_reg_write, id_mem_read, id_waddr};
  assign freeze     = ~enable | ~mem_ready;
  assign redirect   = mem_redirect & mem_q.ctl.valid & ~freeze;
  assign load_use   = hazard & ~freeze & ~redirect;
  assign stall_inc  = (enable & ~mem_ready) | load_use;
  assign unused_ctl = ^{wb_q.ctl.mem_read, mem_q.ctl.mem_read, exe_q.ctl.mem_read};

  hazard_cmp #(.AW(AW), .ZERO_R(ZERO_R != 0)) u_cmp_id_exe (
    .st_wr(exe_q.ctl.valid & exe_q.ctl.reg_write), .st_waddr(exe_q.waddr),
    .src_a(id_rs), .src_b(id_rt), .use_a(id_rs_used), .use_b(id_rt_used),
    .hit_a(ie_a), .hit_b(ie_b)
  );

  hazard_cmp #(.AW(AW), .ZERO_R(ZERO_R != 0)) u_cmp_id_wb (
    .st_wr(wb_q.ctl.valid & wb_q.ctl.reg_write), .st_waddr(wb_q.waddr),
    .src_a(id_rs), .src_b(id_rt), .use_a(id_rs_used), .use_b(id_rt_used),
    .hit_a(iw_a), .hit_b(iw_b)
  );

`ifdef HAZARD_CTRL_FWD_EN
  logic [AW-1:0] exe_rs_q, exe_rt_q;
  logic          exe_rs_used_q, exe_rt_used_q;
  logic          em_a, em_b, ew_a, ew_b;

  hazard_cmp #(.AW(AW), .ZERO_R(ZERO_R != 0)) u_cmp_exe_mem (
    .st_wr(mem_q.ctl.valid & mem_q.ctl.reg_write), .st_waddr(mem_q.waddr),
    .src_a(exe_rs_q), .src_b(exe_rt_q), .use_a(exe_rs_used_q), .use_b(exe_rt_used_q),
    .hit_a(em_a), .hit_b(em_b)
  );

  hazard_cmp #(.AW(AW), .ZERO_R(ZERO_R != 0)) u_cmp_exe_wb (
    .st_wr(wb_q.ctl.valid & wb_q.ctl.reg_write), .st_waddr(wb_q.waddr),
    .src_a(exe_rs_q), .src_b(exe_rt_q), .use_a(exe_rs_used_q), .use_b(exe_rt_used_q),
    .hit_a(ew_a), .hit_b(ew_b)
  );

  // Only a load in EXE is unresolvable; its data is forwarded from WB a cycle later.
  assign hazard   = id_valid & (ie_a | ie_b) & exe_q.ctl.mem_read;
  assign fwd_a    = (em_a & ~mem_q.ctl.mem_read) ? FWD_MEM : (ew_a ? FWD_WB : FWD_RF);
  assign fwd_b    = (em_b & ~mem_q.ctl.mem_read) ? FWD_MEM : (ew_b ? FWD_WB : FWD_RF);
  assign id_byp_a = id_valid & iw_a;
  assign id_byp_b = id_valid & iw_b;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      exe_rs_q      <= '0;
      exe_rt_q      <= '0;
      exe_rs_used_q <= 1'b0;
      exe_rt_used_q <= 1'b0;
    end else if (!freeze) begin
      if (redirect || load_use) begin
        exe_rs_q      <= '0;
        exe_rt_q      <= '0;
        exe_rs_used_q <= 1'b0;
        exe_rt_used_q <= 1'b0;
      end else begin
        exe_rs_q      <= id_rs;
        exe_rt_q      <= id_rt;
        exe_rs_used_q <= id_rs_used;
        exe_rt_used_q <= id_rt_used;
      end
    end
  end
`else
  logic im_a, im_b;

  hazard_cmp #(.AW(AW), .ZERO_R(ZERO_R != 0)) u_cmp_id_mem (
    .st_wr(mem_q.ctl.valid & mem_q.ctl.reg_write), .st_waddr(mem_q.waddr),
    .src_a(id_rs), .src_b(id_rt), .use_a(id_rs_used), .use_b(id_rt_used),
    .hit_a(im_a), .hit_b(im_b)
  );

  // No forwarding paths: hold in ID until the producer has written the regfile.
  assign hazard   = id_valid & (ie_a | ie_b | im_a | im_b | iw_a | iw_b);
  assign fwd_a    = FWD_RF;
  assign fwd_b    = FWD_RF;
  assign id_byp_a = 1'b0;
  assign id_byp_b = 1'b0;
`endif

  always_comb begin
    pc_en         = ~freeze;
    if_id_en      = ~freeze;
    id_exe_en     = ~freeze;
    exe_mem_en    = ~freeze;
    mem_wb_en     = ~freeze;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    if (redirect) begin
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      exe_q   <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= redirect ? '0 : exe_q;
        exe_q <= (redirect || load_use) ? '0 : id_ent;
      end
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (redirect && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written reset/saturation sequences, random vs. reference model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam logic [4:0] AE = 5'b11111;
  localparam logic [4:0] ST = 5'b00111;
  localparam logic [4:0] FZ = 5'b00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n, enable, id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
  logic          mem_redirect, mem_ready;
  logic [AW-1:0] id_rs, id_rt, id_waddr;
  logic          pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
  logic          if_id_flush, id_exe_flush, exe_mem_flush, id_byp_a, id_byp_b;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.AW(AW), .CNT_W(CW), .ZERO_R(1)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_waddr(id_waddr),
    .mem_redirect(mem_redirect), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en), .exe_mem_en(exe_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_flush(exe_mem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  wire [4:0] en_v  = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en};
  wire [2:0] fl_v  = {if_id_flush, id_exe_flush, exe_mem_flush};
  wire [1:0] byp_v = {id_byp_a, id_byp_b};

  typedef struct {
    logic rstn, en, idv, rw, mr, redir, rdy, rsu, rtu;
    logic [4:0] wa, rs, rt;
  } in_t;

  typedef struct {
    in_t        i;
    logic [4:0] xen;
    logic [2:0] xfl;
    logic [1:0] xfa, xfb, xbyp;
    logic [CW-1:0] xsc, xfc;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic in_t ins(input int wa, input int rs, input int rt,
                              input logic rw = 1'b1, input logic mr = 1'b0);
    in_t t;
    t.rstn = 1'b1; t.en = 1'b1; t.idv = 1'b1; t.rw = rw; t.mr = mr;
    t.redir = 1'b0; t.rdy = 1'b1; t.rsu = 1'b1; t.rtu = 1'b1;
    t.wa = 5'(wa); t.rs = 5'(rs); t.rt = 5'(rt);
    return t;
  endfunction

  function automatic in_t nop();
    in_t t;
    t = ins(0, 0, 0, 1'b0, 1'b0);
    t.idv = 1'b0; t.rsu = 1'b0; t.rtu = 1'b0;
    return t;
  endfunction

  function automatic void row(input in_t i, input logic [4:0] xen, input logic [2:0] xfl,
                              input logic [1:0] xfa, input logic [1:0] xfb, input logic [1:0] xbyp,
                              input int xsc, input int xfc);
    vec_t v;
    v.i = i; v.xen = xen; v.xfl = xfl; v.xfa = xfa; v.xfb = xfb; v.xbyp = xbyp;
    v.xsc = CW'(xsc); v.xfc = CW'(xfc);
    vt.push_back(v);
  endfunction

  task automatic drive(input in_t t);
    arst_n = t.rstn; enable = t.en; id_valid = t.idv; id_reg_write = t.rw; id_mem_read = t.mr;
    mem_redirect = t.redir; mem_ready = t.rdy; id_rs_used = t.rsu; id_rt_used = t.rtu;
    id_waddr = t.wa; id_rs = t.rs; id_rt = t.rt;
  endtask

  task automatic run_table();
    foreach (vt[k]) begin
      drive(vt[k].i);
      #2;
      chk($sformatf("vec%0d_en", k), 32'(en_v), 32'(vt[k].xen));
      chk($sformatf("vec%0d_flush", k), 32'(fl_v), 32'(vt[k].xfl));
      chk($sformatf("vec%0d_fwd_a", k), 32'(fwd_a), 32'(vt[k].xfa));
      chk($sformatf("vec%0d_fwd_b", k), 32'(fwd_b), 32'(vt[k].xfb));
      chk($sformatf("vec%0d_byp", k), 32'(byp_v), 32'(vt[k].xbyp));
      chk($sformatf("vec%0d_stall_cnt", k), 32'(stall_cnt), 32'(vt[k].xsc));
      chk($sformatf("vec%0d_flush_cnt", k), 32'(flush_cnt), 32'(vt[k].xfc));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reference model: a queue of in-flight instructions, [0]=EXE [1]=MEM [2]=WB.
  typedef struct {
    logic v, rw, mr, rsu, rtu;
    int   wa, rs, rt;
  } minst_t;

  minst_t pipe[$];
  int     m_sc, m_fc;

  function automatic minst_t bub();
    minst_t b;
    b.v = 1'b0; b.rw = 1'b0; b.mr = 1'b0; b.rsu = 1'b0; b.rtu = 1'b0;
    b.wa = 0; b.rs = 0; b.rt = 0;
    return b;
  endfunction

  function automatic logic hit(input minst_t s, input int r, input logic used);
    return used && s.v && s.rw && (s.wa == r) && (r != 0);
  endfunction

`ifdef HAZARD_CTRL_FWD_EN
  function automatic logic [1:0] fsel(input int r, input logic used);
    if (hit(pipe[1], r, used) && !pipe[1].mr) return 2'b01;
    if (hit(pipe[2], r, used)) return 2'b10;
    return 2'b00;
  endfunction
`endif

  task automatic mreset();
    pipe.delete();
    repeat (3) pipe.push_back(bub());
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic mcyc(input in_t t);
    minst_t     idi;
    logic       frz, rdr, hz, lu;
    logic [4:0] xen;
    logic [2:0] xfl;
    logic [1:0] xfa, xfb, xbyp;
    idi.v = t.idv; idi.rw = t.rw; idi.mr = t.mr; idi.rsu = t.rsu; idi.rtu = t.rtu;
    idi.wa = int'(t.wa); idi.rs = int'(t.rs); idi.rt = int'(t.rt);
    drive(t);
    #2;
    frz = !t.en || !t.rdy;
    rdr = t.redir && pipe[0+1].v && !frz;
`ifdef HAZARD_CTRL_FWD_EN
    hz   = t.idv && pipe[0].mr && (hit(pipe[0], idi.rs, idi.rsu) || hit(pipe[0], idi.rt, idi.rtu));
    xfa  = fsel(pipe[0].rs, pipe[0].rsu);
    xfb  = fsel(pipe[0].rt, pipe[0].rtu);
    xbyp = {t.idv && hit(pipe[2], idi.rs, idi.rsu), t.idv && hit(pipe[2], idi.rt, idi.rtu)};
`else
    hz = 1'b0;
    for (int k = 0; k < 3; k++) hz |= hit(pipe[k], idi.rs, idi.rsu) | hit(pipe[k], idi.rt, idi.rtu);
    hz   = hz && t.idv;
    xfa  = 2'b00;
    xfb  = 2'b00;
    xbyp = 2'b00;
`endif
    lu  = hz && !frz && !rdr;
    xen = frz ? FZ : (lu ? ST : AE);
    xfl = rdr ? 3'b111 : (lu ? 3'b010 : 3'b000);
    chk("rnd_en", 32'(en_v), 32'(xen));
    chk("rnd_flush", 32'(fl_v), 32'(xfl));
    chk("rnd_fwd_a", 32'(fwd_a), 32'(xfa));
    chk("rnd_fwd_b", 32'(fwd_b), 32'(xfb));
    chk("rnd_byp", 32'(byp_v), 32'(xbyp));
    chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("rnd_flush_cnt", 32'(flush_cnt), 32'(m_fc));
    @(posedge clk);
    if (!t.rstn) begin
      mreset();
    end else begin
      if (!frz) begin
        void'(pipe.pop_back());
        if (rdr) pipe[0] = bub();
        pipe.push_front((lu || rdr) ? bub() : idi);
      end
      if (((t.en && !t.rdy) || lu) && m_sc < (1 << CW) - 1) m_sc++;
      if (rdr && m_fc < (1 << CW) - 1) m_fc++;
    end
    @(negedge clk);
  endtask

  initial begin
    in_t t;
    int  s0;

    // Writes to r0 never create hazards.
    row(ins(0, 1, 0, 1'b1, 1'b1), AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(0, 1, 2),             AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(4, 0, 0),             AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),                    AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),                    AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),                    AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
`ifdef HAZARD_CTRL_FWD_EN
    // add r3,r1,r2; sub r4,r3,r5
    row(ins(3, 1, 2), AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(4, 3, 5), AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),        AE, 3'b000, 2'b01, 2'b00, 2'b00, 0, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    // add r3; nop; or r6,r3,r7; and r8,r3,r3
    row(ins(3, 1, 2), AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(6, 3, 7), AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(8, 3, 3), AE, 3'b000, 2'b10, 2'b00, 2'b11, 0, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    // lw r2,0(r1); add r4,r2,r2
    row(ins(2, 1, 0, 1'b1, 1'b1), AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(4, 2, 2),             ST, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(4, 2, 2),             AE, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
    row(nop(),                    AE, 3'b000, 2'b10, 2'b10, 2'b00, 1, 0);
    row(nop(),                    AE, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
    row(nop(),                    AE, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
    s0 = 1;
`else
    // add r3,r1,r2; add r4,r3,r5 -> three bubbles
    row(ins(3, 1, 2), AE, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(4, 3, 5), ST, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0);
    row(ins(4, 3, 5), ST, 3'b010, 2'b00, 2'b00, 2'b00, 1, 0);
    row(ins(4, 3, 5), ST, 3'b010, 2'b00, 2'b00, 2'b00, 2, 0);
    row(ins(4, 3, 5), AE, 3'b000, 2'b00, 2'b00, 2'b00, 3, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 3, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 3, 0);
    row(nop(),        AE, 3'b000, 2'b00, 2'b00, 2'b00, 3, 0);
    s0 = 3;
`endif
    // Taken beq in MEM during a 3-cycle memory wait, then flush.
    row(ins(0, 1, 2, 1'b0, 1'b0), AE, 3'b000, 2'b00, 2'b00, 2'b00, s0, 0);
    t = nop(); t.redir = 1'b1;
    row(t, AE, 3'b000, 2'b00, 2'b00, 2'b00, s0, 0);
    t.rdy = 1'b0;
    row(t, FZ, 3'b000, 2'b00, 2'b00, 2'b00, s0, 0);
    row(t, FZ, 3'b000, 2'b00, 2'b00, 2'b00, s0 + 1, 0);
    row(t, FZ, 3'b000, 2'b00, 2'b00, 2'b00, s0 + 2, 0);
    t.rdy = 1'b1;
    row(t, AE, 3'b111, 2'b00, 2'b00, 2'b00, s0 + 3, 0);
    row(nop(), AE, 3'b000, 2'b00, 2'b00, 2'b00, s0 + 3, 1);

    t = nop(); t.rstn = 1'b0;
    drive(t);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(nop());
    #2;
    chk("reset_en", 32'(en_v), 32'(AE));
    chk("reset_flush", 32'(fl_v), 32'd0);
    chk("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("reset_byp", 32'(byp_v), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);

    run_table();

    // Reset asserted in the middle of a frozen load/use stall.
    drive(ins(3, 1, 2, 1'b1, 1'b1));
    @(posedge clk); @(negedge clk);
    t = ins(5, 3, 3); t.rdy = 1'b0;
    drive(t);
    #2;
    chk("freeze_en", 32'(en_v), 32'(FZ));
    repeat (2) @(posedge clk);
    @(negedge clk);
    t.rstn = 1'b0;
    drive(t);
    @(posedge clk); @(negedge clk);
    t.rstn = 1'b1; t.rdy = 1'b1;
    drive(t);
    #2;
    chk("post_rst_en", 32'(en_v), 32'(AE));
    chk("post_rst_flush", 32'(fl_v), 32'd0);
    chk("post_rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("post_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk); @(negedge clk);
    t = nop(); t.en = 1'b0;
    drive(t);
    #2;
    chk("disabled_en", 32'(en_v), 32'(FZ));
    @(posedge clk); @(negedge clk);
    chk("disabled_stall_cnt", 32'(stall_cnt), 32'd0);

    // Stall counter saturates rather than wrapping.
    t = nop(); t.rdy = 1'b0;
    drive(t);
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'((1 << CW) - 1));

    // Randomised traffic against the reference model.
    t = nop(); t.rstn = 1'b0;
    drive(t);
    @(posedge clk); @(negedge clk);
    mreset();
    for (int n = 0; n < 1500; n++) begin
      t.rstn  = ($urandom_range(99) != 0);
      t.en    = ($urandom_range(19) != 0);
      t.idv   = ($urandom_range(9) != 0);
      t.rw    = ($urandom_range(3) != 0);
      t.mr    = ($urandom_range(3) == 0);
      t.redir = ($urandom_range(9) == 0);
      t.rdy   = ($urandom_range(4) != 0);
      t.rsu   = t.idv && ($urandom_range(3) != 0);
      t.rtu   = t.idv && ($urandom_range(3) != 0);
      t.wa    = 5'($urandom_range(3));
      t.rs    = 5'($urandom_range(3));
      t.rt    = 5'($urandom_range(3));
      mcyc(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
